// File: rtl/alu_pkg.sv
// Shared opcode constants and helpers for the RV32I integer ALU.
// Opcode encoding is {funct3, funct7[5]}.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1110;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;

  // Compares reuse the adder in subtract mode.
  function automatic logic needs_sub(
    input logic [3:0] sel
  );
    return (sel == ALU_SUB) ||
           (sel == ALU_SLT) ||
           (sel == ALU_SLTU);
  endfunction

  function automatic logic [31:0] bit_rev(
    input logic [31:0] v
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Single barrel shifter for SLL, SRL and SRA.
// Left shifts reuse the right-shift stages via bit reversal.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [4:0]  amount,
  input  logic        left,
  input  logic        arith,
  output logic [31:0] result
);

  logic        fill;
  logic [31:0] s0;
  logic [31:0] s1;
  logic [31:0] s2;
  logic [31:0] s3;
  logic [31:0] s4;
  logic [31:0] s5;

  // Log-depth right shifter; sign fill only for SRA.
  always_comb begin
    fill = arith & ~left & data[31];
    s0 = left ? bit_rev(data) : data;
    s1 = amount[0] ?
      {{1{fill}}, s0[31:1]} : s0;
    s2 = amount[1] ?
      {{2{fill}}, s1[31:2]} : s1;
    s3 = amount[2] ?
      {{4{fill}}, s2[31:4]} : s2;
    s4 = amount[3] ?
      {{8{fill}}, s3[31:8]} : s3;
    s5 = amount[4] ?
      {{16{fill}}, s4[31:16]} : s4;
    result = left ? bit_rev(s5) : s5;
  end

endmodule

// File: rtl/alu.sv
// RV32I integer ALU: add/sub, logic, shifts, compares, zero flag.
// Define ALU_OUT_REG_EN for a registered (1-cycle) output.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data1,
  input  logic [31:0] in_data2,
  input  logic [3:0]  in_select,
  output logic [31:0] out_data,
  output logic        out_zero
);

  logic        sub_mode;
  logic [31:0] b_op;
  logic [32:0] sum;
  logic        lt_s;
  logic        lt_u;
  logic        sh_left;
  logic        sh_arith;
  logic [31:0] sh_res;
  logic [31:0] res;
  logic        res_zero;

  // One adder: B inverted plus carry-in for SUB and compares.
  always_comb begin
    sub_mode = needs_sub(in_select);
    b_op = sub_mode ? ~in_data2 : in_data2;
    sum = {1'b0, in_data1} +
          {1'b0, b_op} +
          {32'b0, sub_mode};
  end

  // Compares from the subtract: no carry out means A < B.
  always_comb begin
    lt_u = ~sum[32];
    lt_s = (in_data1[31] ^ in_data2[31]) ?
      in_data1[31] : sum[31];
  end

  // Shifter control from the opcode.
  always_comb begin
    sh_left  = (in_select == ALU_SLL);
    sh_arith = (in_select == ALU_SRA);
  end

  alu_shifter u_shifter (
    .data   (in_data1),
    .amount (in_data2[4:0]),
    .left   (sh_left),
    .arith  (sh_arith),
    .result (sh_res)
  );

  // Result select; unused opcodes give zero.
  always_comb begin
    res = 32'h0;
    unique case (in_select)
      ALU_ADD,
      ALU_SUB:  res = sum[31:0];
      ALU_XOR:  res = in_data1 ^ in_data2;
      ALU_OR:   res = in_data1 | in_data2;
      ALU_AND:  res = in_data1 & in_data2;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  res = sh_res;
      ALU_SLT:  res = {31'b0, lt_s};
      ALU_SLTU: res = {31'b0, lt_u};
      default:  res = 32'h0;
    endcase
    res_zero = (res == 32'h0);
  end

`ifdef ALU_OUT_REG_EN
  // Output register; reset wins over capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= 32'h0;
      out_zero <= 1'b1;
    end else begin
      out_data <= res;
      out_zero <= res_zero;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign out_data = res;
  assign out_zero = res_zero;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: random and directed ops vs. a model.
// Works for both the combinational and registered builds.
module tb_alu;

`ifdef ALU_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] in_data1;
  logic [31:0] in_data2;
  logic [3:0]  in_select;
  logic [31:0] out_data;
  logic        out_zero;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        z;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_select (in_select),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] model(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  sel
  );
    int unsigned sh;
    sh = b % 32;
    case (sel)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1000: return a ^ b;
      4'b1100: return a | b;
      4'b1110: return a & b;
      4'b0010: return a << sh;
      4'b1010: return a >> sh;
      4'b1011: return $unsigned($signed(a) >>> sh);
      4'b0100: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'b0110: return (a < b) ? 1 : 0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic issue(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  sel,
    input logic        r,
    input string       name
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    in_data1 = a;
    in_data2 = b;
    in_select = sel;
    e.due = cyc + LAT;
    e.d = model(a, b, sel);
`ifdef ALU_OUT_REG_EN
    if (r) e.d = 32'h0;
`endif
    e.z = (e.d == 32'h0);
    e.name = name;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (e.due != cyc || out_data !== e.d ||
          out_zero !== e.z) begin
        n_fail++;
        $display("FAIL %s: got data=%h zero=%b, want data=%h zero=%b",
                 e.name, out_data, out_zero, e.d, e.z);
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int wait_cyc;
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    in_data1 = 32'h0;
    in_data2 = 32'h0;
    in_select = 4'b0000;

    issue(32'h0, 32'h0, 4'b0000, 1'b1, "reset0");
    issue(32'h0, 32'h0, 4'b0000, 1'b1, "reset1");

    issue(32'd1, 32'd2, 4'b0000, 1'b0, "add_1_2");
    issue(32'd0, 32'd0, 4'b0000, 1'b0, "add_0_0");
    issue(32'd1, 32'd2, 4'b0001, 1'b0, "sub_1_2");
    issue(32'hFFFF_FFFF, 32'd1, 4'b0000, 1'b0, "add_wrap");
    issue(32'd2, 32'd4, 4'b1000, 1'b0, "xor_2_4");
    issue(32'd3, 32'd4, 4'b1100, 1'b0, "or_3_4");
    issue(32'd3, 32'd2, 4'b1110, 1'b0, "and_3_2");
    issue(32'd9, 32'd9, 4'b1000, 1'b0, "xor_9_9");
    issue(32'd1, 32'd5, 4'b0010, 1'b0, "sll_1_5");
    issue(32'd17, 32'd1, 4'b1010, 1'b0, "srl_17_1");
    issue(32'hFFFF_FFFF, 32'd2, 4'b1011, 1'b0, "sra_ones");
    issue(32'h8000_0000, 32'd31, 4'b1011, 1'b0, "sra_msb");
    issue(32'd1, 32'h21, 4'b0010, 1'b0, "sll_b5");
    issue(32'h8000_0001, 32'd32, 4'b1011, 1'b0, "sra_32");
    issue(-32'sd10, 32'd5, 4'b0100, 1'b0, "slt_neg");
    issue(32'd10, 32'd5, 4'b0100, 1'b0, "slt_pos");
    issue(-32'sd10, 32'd5, 4'b0110, 1'b0, "sltu_big");
    issue(32'd5, 32'd10, 4'b0110, 1'b0, "sltu_small");
    issue(32'd7, 32'd3, 4'b0011, 1'b0, "undef_0011");
    issue(32'd7, 32'd3, 4'b1111, 1'b0, "undef_1111");

    issue(32'd1, 32'd2, 4'b0000, 1'b0, "pre_rst");
    issue(32'd5, 32'd6, 4'b0000, 1'b1, "mid_rst");
    issue(32'd4, 32'd4, 4'b0000, 1'b0, "post_rst");

    for (int i = 0; i < 300; i++) begin
      issue(pick(), pick(),
            4'($urandom_range(0, 15)),
            1'b0, "random");
    end

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no output, want data=%h",
               e.name, e.d);
    end

    @(posedge clk);
    #1;
    rst = 1'b0;
    in_data1 = 32'd1;
    in_data2 = 32'd2;
    in_select = 4'b0000;
    repeat (LAT) @(posedge clk);
    #1;
    n_checks++;
    if (out_data !== 32'd3 || out_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL dir_add: got data=%h zero=%b",
               out_data, out_zero);
    end

    @(posedge clk);
    #1;
    in_data1 = 32'd1;
    in_data2 = 32'd2;
    in_select = 4'b0001;
    repeat (LAT) @(posedge clk);
    #1;
    n_checks++;
    if (out_data !== 32'hFFFF_FFFF || out_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL dir_sub: got data=%h zero=%b",
               out_data, out_zero);
    end

    @(posedge clk);
    #1;
    in_data1 = 32'd9;
    in_data2 = 32'd9;
    in_select = 4'b1000;
    repeat (LAT) @(posedge clk);
    #1;
    n_checks++;
    if (out_data !== 32'h0 || out_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dir_xor: got data=%h zero=%b",
               out_data, out_zero);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
